// File: rtl/autoconfig_master_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// autoconfig_master_if : 68000-style config-space bus (A[23:1], D[15:12]).
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
interface autoconfig_master_if;
  logic [22:0] ADDR;
  logic [3:0]  DOUT;
  logic        DOE;
  logic [3:0]  DIN;
  logic        ASn;
  logic        UDSn;
  logic        RWn;

  modport master (output ADDR, DOUT, DOE, ASn, UDSn, RWn, input DIN);
  modport slave  (input ADDR, DOUT, DOE, ASn, UDSn, RWn, output DIN);
endinterface
`default_nettype wire

// File: rtl/autoconfig_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// autoconfig_master : Zorro II autoconfig initiator; reads each board on the
// config chain, places FastRAM in $200000-$9FFFFF, writes base or shut-up.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module autoconfig_master #(
  parameter int BUS_CLKS   = 4,
  parameter int IDLE_CLKS  = 2,
  parameter int MAX_BOARDS = 8
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      START,
  autoconfig_master_if.master       bus,
  output logic                      CFGOUTn,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      ERR,
  output logic [3:0]                NUM_CONFIG,
  output logic [7:0]                MEM_MAP,
  output logic [15:0]               LAST_MFG,
  output logic [7:0]                LAST_PROD
);

  localparam int       c_BCW      = $clog2(MAX_BOARDS + 1);
  localparam bit [3:0] c_LOW_END  = 4'(BUS_CLKS - 1);
  localparam bit [3:0] c_HIGH_END = 4'(IDLE_CLKS - 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_DECIDE  = 3'd2,
    S_WR_BASE = 3'd3,
    S_SHUTUP  = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    P_LAUNCH = 2'd0,
    P_LOW    = 2'd1,
    P_HIGH   = 2'd2
  } phase_t;

  state_t             r_state;
  phase_t             r_phase;
  logic [3:0]         r_cnt;
  logic [2:0]         r_ridx;
  logic [2:0]         r_type;
  logic [2:0]         r_size;
  logic [3:0]         r_base;
  logic [c_BCW-1:0]   r_boards;
  logic [22:0]        r_addr;
  logic [3:0]         r_dout;
  logic               r_doe;
  logic               r_as_n;
  logic               r_uds_n;
  logic               r_rw_n;
  logic               r_cfgout_n;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [3:0]         r_num;
  logic [7:0]         r_mem_map;
  logic [15:0]        r_mfg;
  logic [7:0]         r_prod;

  logic [7:0]         w_reg;
  logic [3:0]         w_wdata;
  logic               w_read;
  logic [7:0]         w_kmask;
  logic [2:0]         w_amask;
  logic               w_found;
  logic [2:0]         w_base;
  logic [7:0]         w_field;

  // Register offset and write data of the access the current state performs
  always_comb begin
    w_reg   = 8'h00;
    w_wdata = 4'h0;
    w_read  = 1'b0;
    case (r_state)
      S_READ: begin
        w_reg  = {4'h0, r_ridx[2], 1'b0, r_ridx[1:0]};
        w_read = 1'b1;
      end
      S_WR_BASE: begin
        w_reg   = 8'h24;
        w_wdata = r_base;
      end
      S_SHUTUP: w_reg = 8'h26;
      default: ;
    endcase
  end

  // Size code to slot mask (k ones) and alignment mask (k-1)
  always_comb begin
    w_kmask = 8'h00;
    w_amask = 3'd0;
    case (r_size)
      3'b000: begin w_kmask = 8'hFF; w_amask = 3'd7; end
      3'b111: begin w_kmask = 8'h0F; w_amask = 3'd3; end
      3'b110: begin w_kmask = 8'h03; w_amask = 3'd1; end
      3'b101: begin w_kmask = 8'h01; w_amask = 3'd0; end
      default: ;
    endcase
  end

  // Descending scan so the lowest free aligned slot wins
  always_comb begin
    w_found = 1'b0;
    w_base  = 3'd0;
    w_field = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      if (w_kmask != 8'h00 && (3'(i) & w_amask) == 3'd0 &&
          (r_mem_map & (w_kmask << i)) == 8'h00) begin
        w_found = 1'b1;
        w_base  = 3'(i);
        w_field = w_kmask << i;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_phase    <= P_LAUNCH;
      r_cnt      <= 4'd0;
      r_ridx     <= 3'd0;
      r_type     <= 3'd0;
      r_size     <= 3'd0;
      r_base     <= 4'd0;
      r_boards   <= '0;
      r_addr     <= 23'd0;
      r_dout     <= 4'd0;
      r_doe      <= 1'b0;
      r_as_n     <= 1'b1;
      r_uds_n    <= 1'b1;
      r_rw_n     <= 1'b1;
      r_cfgout_n <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_num      <= 4'd0;
      r_mem_map  <= 8'h00;
      r_mfg      <= 16'h0000;
      r_prod     <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_cfgout_n <= 1'b0;
            r_busy     <= 1'b1;
            r_ridx     <= 3'd0;
            r_phase    <= P_LAUNCH;
            r_state    <= S_READ;
          end
        end

        S_READ, S_WR_BASE, S_SHUTUP: begin
          case (r_phase)
            P_LAUNCH: begin
              r_addr  <= {8'hE8, 7'd0, w_reg};
              r_dout  <= w_wdata;
              r_doe   <= !w_read;
              r_rw_n  <= w_read;
              r_as_n  <= 1'b0;
              r_uds_n <= 1'b0;
              r_cnt   <= 4'd0;
              r_phase <= P_LOW;
            end
            P_LOW: begin
              if (r_cnt == c_LOW_END) begin
                r_as_n  <= 1'b1;
                r_uds_n <= 1'b1;
                r_cnt   <= 4'd0;
                r_phase <= P_HIGH;
                if (r_state == S_READ) begin
                  case (r_ridx)
                    3'd0: r_type        <= bus.DIN[3:1];
                    3'd1: r_size        <= bus.DIN[2:0];
                    3'd2: r_prod[7:4]   <= ~bus.DIN;
                    3'd3: r_prod[3:0]   <= ~bus.DIN;
                    3'd4: r_mfg[15:12]  <= ~bus.DIN;
                    3'd5: r_mfg[11:8]   <= ~bus.DIN;
                    3'd6: r_mfg[7:4]    <= ~bus.DIN;
                    3'd7: r_mfg[3:0]    <= ~bus.DIN;
                  endcase
                end
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end
            P_HIGH: begin
              if (r_cnt == 4'd0) begin
                r_addr <= 23'd0;
                r_dout <= 4'd0;
                r_doe  <= 1'b0;
                r_rw_n <= 1'b1;
              end
              // The following LAUNCH cycle is the last strobe-high cycle
              if (r_cnt == c_HIGH_END) begin
                r_cnt   <= 4'd0;
                r_phase <= P_LAUNCH;
                if (r_state == S_READ) begin
                  if (r_ridx == 3'd0 && r_type[2:1] != 2'b11) begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_FINISH;
                  end else if (r_ridx == 3'd7) begin
                    r_state <= S_DECIDE;
                  end else begin
                    r_ridx <= r_ridx + 3'd1;
                  end
                end else begin
                  if (r_state == S_WR_BASE && r_num != 4'hF)
                    r_num <= r_num + 4'd1;
                  if (r_boards == c_BCW'(MAX_BOARDS - 1)) begin
                    r_err   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_FINISH;
                  end else begin
                    r_boards <= r_boards + 1'b1;
                    r_ridx   <= 3'd0;
                    r_state  <= S_READ;
                  end
                end
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end
            default: r_phase <= P_LAUNCH;
          endcase
        end

        S_DECIDE: begin
          if (!r_type[0] || w_kmask == 8'h00) begin
            r_state <= S_SHUTUP;
          end else if (w_found) begin
            r_mem_map <= r_mem_map | w_field;
            r_base    <= {1'b0, w_base} + 4'd2;
            r_state   <= S_WR_BASE;
          end else begin
            r_err   <= 1'b1;
            r_state <= S_SHUTUP;
          end
        end

        S_FINISH: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ADDR   = r_addr;
  assign bus.DOUT   = r_dout;
  assign bus.DOE    = r_doe;
  assign bus.ASn    = r_as_n;
  assign bus.UDSn   = r_uds_n;
  assign bus.RWn    = r_rw_n;
  assign CFGOUTn    = r_cfgout_n;
  assign BUSY       = r_busy;
  assign DONE       = r_done;
  assign ERR        = r_err;
  assign NUM_CONFIG = r_num;
  assign MEM_MAP    = r_mem_map;
  assign LAST_MFG   = r_mfg;
  assign LAST_PROD  = r_prod;

endmodule
`default_nettype wire

// File: tb/tb_autoconfig_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_autoconfig_master : board-chain model with a transaction scoreboard.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_autoconfig_master;

  localparam int BUS_CLKS  = 4;
  localparam int IDLE_CLKS = 2;

  typedef struct packed {
    logic        rwn;
    logic [22:0] addr;
    logic [3:0]  data;
  } xact_t;

  typedef struct packed {
    logic        err;
    logic [3:0]  num;
    logic [7:0]  map;
    logic [15:0] mfg;
    logic [7:0]  prod;
  } stat_t;

  logic        CLK   = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic        CFGOUTn, BUSY, DONE, ERR;
  logic [3:0]  NUM_CONFIG;
  logic [7:0]  MEM_MAP;
  logic [15:0] LAST_MFG;
  logic [7:0]  LAST_PROD;

  autoconfig_master_if bus();

  autoconfig_master #(
    .BUS_CLKS  (BUS_CLKS),
    .IDLE_CLKS (IDLE_CLKS),
    .MAX_BOARDS(8)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .bus       (bus),
    .CFGOUTn   (CFGOUTn),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR),
    .NUM_CONFIG(NUM_CONFIG),
    .MEM_MAP   (MEM_MAP),
    .LAST_MFG  (LAST_MFG),
    .LAST_PROD (LAST_PROD)
  );

  always #5 CLK = ~CLK;

  // Board chain: entries with index >= n_boards read as empty slots
  logic [3:0]  b_t    [8];
  logic [3:0]  b_z    [8];
  logic [7:0]  b_prod [8];
  logic [15:0] b_mfg  [8];
  int          n_boards = 0;
  int          cur      = 0;
  logic [3:0]  w_din;

  always_comb begin
    w_din = 4'h0;
    if (cur < n_boards) begin
      case (bus.ADDR[7:0])
        8'h00: w_din = b_t[cur[2:0]];
        8'h01: w_din = b_z[cur[2:0]];
        8'h02: w_din = ~b_prod[cur[2:0]][7:4];
        8'h03: w_din = ~b_prod[cur[2:0]][3:0];
        8'h08: w_din = ~b_mfg[cur[2:0]][15:12];
        8'h09: w_din = ~b_mfg[cur[2:0]][11:8];
        8'h0A: w_din = ~b_mfg[cur[2:0]][7:4];
        8'h0B: w_din = ~b_mfg[cur[2:0]][3:0];
        default: w_din = 4'h0;
      endcase
    end
  end
  assign bus.DIN = w_din;

  xact_t exp_x[$];
  stat_t exp_s[$];
  int    n_vec  = 0;
  int    n_fail = 0;
  int    req    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] acc_addr(input logic [7:0] r);
    return {8'hE8, 7'd0, r};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic  rst_q = 1'b1;
  always @(posedge CLK) rst_q <= RESET;

  logic  prev_as   = 1'b1;
  logic  prev_done = 1'b0;
  logic  have_prev = 1'b0;
  logic  prev_0b   = 1'b0;
  logic  watch_doe = 1'b0;
  int    cyc = 0, last_start = 0;
  xact_t x;
  stat_t s;

  always @(negedge CLK) begin
    if (rst_q) begin
      chk("rst_ctl", 64'({bus.ASn, bus.UDSn, bus.RWn, CFGOUTn, bus.DOE, BUSY, DONE, ERR}), 64'h0F0);
      chk("rst_bus", 64'({bus.ADDR, bus.DOUT}), 64'h0);
      chk("rst_stat", 64'({NUM_CONFIG, MEM_MAP, LAST_MFG, LAST_PROD}), 64'h0);
      cur       = 0;
      prev_as   = 1'b1;
      prev_done = 1'b0;
      have_prev = 1'b0;
      prev_0b   = 1'b0;
      watch_doe = 1'b0;
    end else begin
      if (prev_as && !bus.ASn) begin
        chk("uds_fall", 64'(bus.UDSn), 64'h0);
        if (exp_x.size() == 0) begin
          chk("unexpected_access", 64'(bus.ADDR), 64'h0);
        end else begin
          x = exp_x.pop_front();
          chk("acc_rwn", 64'(bus.RWn), 64'(x.rwn));
          chk("acc_addr", 64'(bus.ADDR), 64'(x.addr));
          chk("acc_doe_dout", 64'({bus.DOE, bus.DOUT}), x.rwn ? 64'h0 : 64'({1'b1, x.data}));
        end
        if (have_prev && !prev_0b)
          chk("access_period", 64'(cyc - last_start), 64'(BUS_CLKS + IDLE_CLKS));
        have_prev  = 1'b1;
        prev_0b    = (bus.ADDR[7:0] == 8'h0B);
        last_start = cyc;
      end else if (!prev_as && bus.ASn) begin
        chk("low_width", 64'(cyc - last_start), 64'(BUS_CLKS));
        chk("uds_rise", 64'(bus.UDSn), 64'h1);
        if (!bus.RWn) begin
          chk("doe_hold", 64'(bus.DOE), 64'h1);
          watch_doe = 1'b1;
          if (bus.ADDR[7:0] == 8'h24 || bus.ADDR[7:0] == 8'h26) cur = cur + 1;
        end
      end else if (watch_doe) begin
        chk("doe_drop", 64'(bus.DOE), 64'h0);
        watch_doe = 1'b0;
      end

      if (!prev_done && DONE) begin
        if (exp_s.size() == 0) begin
          chk("unexpected_done", 64'(DONE), 64'h0);
        end else begin
          s = exp_s.pop_front();
          chk("done_busy_cfg", 64'({BUSY, CFGOUTn}), 64'h0);
          chk("done_err", 64'(ERR), 64'(s.err));
          chk("done_num", 64'(NUM_CONFIG), 64'(s.num));
          chk("done_map", 64'(MEM_MAP), 64'(s.map));
          chk("done_ids", 64'({LAST_MFG, LAST_PROD}), 64'({s.mfg, s.prod}));
        end
      end
      prev_as   = bus.ASn;
      prev_done = DONE;
    end
    if (req == 1) chk("queues_drained", 64'(exp_x.size() + exp_s.size()), 64'h0);
    if (req == 2) chk("timeout", 64'h1, 64'h0);
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic request(input int k);
    @(posedge CLK); #1 req = k;
    @(negedge CLK); #1 req = 0;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1 RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
  endtask

  task automatic set_board(input int i, input logic [3:0] t, input logic [3:0] z,
                           input logic [7:0] prod, input logic [15:0] mfg);
    b_t[i] = t; b_z[i] = z; b_prod[i] = prod; b_mfg[i] = mfg;
  endtask

  task automatic exp_reads();
    logic [7:0] regs [8];
    regs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h08, 8'h09, 8'h0A, 8'h0B};
    for (int i = 0; i < 8; i++) exp_x.push_back('{1'b1, acc_addr(regs[i]), 4'h0});
  endtask

  task automatic exp_absent();
    exp_x.push_back('{1'b1, acc_addr(8'h00), 4'h0});
  endtask

  task automatic exp_w(input logic [7:0] r, input logic [3:0] d);
    exp_x.push_back('{1'b0, acc_addr(r), d});
  endtask

  task automatic exp_stat(input logic err, input logic [3:0] num, input logic [7:0] map,
                          input logic [15:0] mfg, input logic [7:0] prod);
    exp_s.push_back('{err, num, map, mfg, prod});
  endtask

  task automatic pulse_start();
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
  endtask

  // A second START arrives mid-enumeration and must be ignored
  task automatic run();
    bit seen;
    seen = 1'b0;
    pulse_start();
    repeat (30) @(posedge CLK);
    pulse_start();
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge CLK);
      if (DONE) seen = 1'b1;
    end
    if (!seen) request(2);
    repeat (2) @(negedge CLK);
    request(1);
  endtask

  initial begin
    bit found;

    // 8 MB board, then empty slot
    do_reset();
    set_board(0, 4'hE, 4'h0, 8'h45, 16'h07DB); n_boards = 1;
    exp_reads(); exp_w(8'h24, 4'd2); exp_absent();
    exp_stat(1'b0, 4'd1, 8'hFF, 16'h07DB, 8'h45);
    run();

    // 2 MB then 4 MB -> bases 2 and 6
    do_reset();
    set_board(0, 4'hE, 4'h6, 8'h11, 16'h0101);
    set_board(1, 4'hE, 4'h7, 8'h56, 16'h1234); n_boards = 2;
    exp_reads(); exp_w(8'h24, 4'd2);
    exp_reads(); exp_w(8'h24, 4'd6); exp_absent();
    exp_stat(1'b0, 4'd2, 8'hF3, 16'h1234, 8'h56);
    run();

    // 8 MB then 4 MB -> second board shut up for lack of space
    do_reset();
    set_board(0, 4'hE, 4'h0, 8'h01, 16'h0202);
    set_board(1, 4'hE, 4'h7, 8'h9A, 16'h0BEE); n_boards = 2;
    exp_reads(); exp_w(8'h24, 4'd2);
    exp_reads(); exp_w(8'h26, 4'd0); exp_absent();
    exp_stat(1'b1, 4'd1, 8'hFF, 16'h0BEE, 8'h9A);
    run();

    // I/O board, sub-1MB memory board, then 1 MB board
    do_reset();
    set_board(0, 4'hC, 4'h0, 8'h21, 16'h0303);
    set_board(1, 4'hE, 4'h4, 8'h22, 16'h0404);
    set_board(2, 4'hE, 4'h5, 8'h33, 16'h5678); n_boards = 3;
    exp_reads(); exp_w(8'h26, 4'd0);
    exp_reads(); exp_w(8'h26, 4'd0);
    exp_reads(); exp_w(8'h24, 4'd2); exp_absent();
    exp_stat(1'b0, 4'd1, 8'h01, 16'h5678, 8'h33);
    run();

    // MAX_BOARDS I/O boards -> forced finish with ERR
    do_reset();
    for (int i = 0; i < 8; i++) set_board(i, 4'hC, 4'h0, 8'(i), 16'h1000 + 16'(i));
    n_boards = 8;
    for (int i = 0; i < 8; i++) begin exp_reads(); exp_w(8'h26, 4'd0); end
    exp_stat(1'b1, 4'd0, 8'h00, 16'h1007, 8'h07);
    run();

    // RESET during the base-address write strobe, then a clean rerun
    do_reset();
    set_board(0, 4'hE, 4'h5, 8'h12, 16'hABCD); n_boards = 1;
    exp_reads(); exp_w(8'h24, 4'd2);
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge CLK);
      if (!bus.ASn && !bus.RWn) found = 1'b1;
    end
    if (!found) request(2);
    #1 RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    request(1);
    exp_reads(); exp_w(8'h24, 4'd2); exp_absent();
    exp_stat(1'b0, 4'd1, 8'h01, 16'hABCD, 8'h12);
    run();

    repeat (2) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
